step_pulse_tracker: RTL and testbench

- Receive-side counterpart of the step-motor pulse generator: consumes one motor's drive/dir/ms/xen/xrst lines.
- Tracks absolute position in finest-microstep units, measures step period and reports motion state.
- Emulates the zero-position detector (zpd) fed back to the generator.
- Flags protocol faults. Used as a bench/loopback model and as an on-chip position monitor.

---
 rtl/step_motor_pkg.sv | 22 ++
 rtl/step_input_sync.sv | 25 ++
 rtl/step_pulse_tracker.sv | 186 ++++++++++++++++++
 tb/tb_step_pulse_tracker.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_motor_pkg.sv
// Shared types for the step-motor pulse tracker: state encoding, fault codes,
// and the microstep-to-position-weight mapping.
package step_motor_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_MOVING   = 2'd2
    } track_state_e;

    localparam logic [1:0] FAULT_NONE          = 2'b00;
    localparam logic [1:0] FAULT_STEP_DISABLED = 2'b01;
    localparam logic [1:0] FAULT_OVERSPEED     = 2'b10;

    // Position increment, in finest-microstep units, of one step taken at microstep k.
    function automatic logic [31:0] ms_weight(input logic [7:0] ms, input int unsigned ms_width);
        int unsigned finest;
        finest = (32'd1 << ms_width) - 32'd1;
        return 32'd1 << (finest - 32'(ms));
    endfunction

endpackage

// File: rtl/step_input_sync.sv
// N-stage multi-bit synchronizer, all stages reset to zero.
module step_input_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/step_pulse_tracker.sv
// Receive-side step-motor tracker: position, step period, motion state, zpd, faults.
// Optional macro STEP_PULSE_TRACKER_REVERSAL_EN adds the o_reversals counter.
module step_pulse_tracker
    import step_motor_pkg::*;
#(
    parameter int unsigned C_MICROSTEP_WIDTH = 3,
    parameter int unsigned C_POSITION_WIDTH  = 32,
    parameter int unsigned C_PERIOD_WIDTH    = 24,
    parameter int unsigned C_SYNC_STAGES     = 2,
    parameter int unsigned C_IDLE_TIMEOUT    = 1000000,
    parameter int unsigned C_MIN_PERIOD      = 32,
    parameter int          C_ZPD_THRESHOLD   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          m_drive,
    input  logic                          m_dir,
    input  logic [C_MICROSTEP_WIDTH-1:0]  m_ms,
    input  logic                          m_xen,
    input  logic                          m_xrst,
    input  logic                          preload_en,
    input  logic [C_POSITION_WIDTH-1:0]   preload_val,
    input  logic                          clr_fault,
    output logic [C_POSITION_WIDTH-1:0]   o_position,
    output logic                          o_zpd,
    output logic [C_PERIOD_WIDTH-1:0]     o_period,
    output logic                          o_period_valid,
    output logic                          o_moving,
    output logic                          o_fault,
    output logic [1:0]                    o_fault_code
`ifdef STEP_PULSE_TRACKER_REVERSAL_EN
   ,output logic [15:0]                   o_reversals
`endif
);

    localparam int unsigned MSW    = C_MICROSTEP_WIDTH;
    localparam int unsigned POSW   = C_POSITION_WIDTH;
    localparam int unsigned PW     = C_PERIOD_WIDTH;
    localparam int unsigned SYNC_W = MSW + 4;
    localparam logic signed [POSW-1:0] ZPD_TH = POSW'(C_ZPD_THRESHOLD);
    localparam logic [PW-1:0] IDLE_TO   = PW'(C_IDLE_TIMEOUT);
    localparam logic [PW-1:0] MIN_PER   = PW'(C_MIN_PERIOD);
    localparam logic          ZPD_RESET = (C_ZPD_THRESHOLD >= 0);

    logic [SYNC_W-1:0] sync_q;
    logic              drive_s, dir_s, xen_s, xrst_s;
    logic [MSW-1:0]    ms_s;

    step_input_sync #(.WIDTH(SYNC_W), .STAGES(C_SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   ({m_drive, m_dir, m_ms, m_xen, m_xrst}),
        .q_o   (sync_q)
    );

    assign drive_s = sync_q[SYNC_W-1];
    assign dir_s   = sync_q[SYNC_W-2];
    assign ms_s    = sync_q[2 +: MSW];
    assign xen_s   = sync_q[1];
    assign xrst_s  = sync_q[0];

    track_state_e    state_q;
    logic            drive_prev_q, edge_q, dir_e_q, first_q;
    logic [MSW-1:0]  ms_e_q;
    logic [PW-1:0]   cnt_q, period_q;
    logic [POSW-1:0] pos_q;
    logic            period_valid_q, moving_q, fault_q, zpd_q;
    logic [1:0]      fault_code_q;

    logic            disabled, accept, reject;
    logic [PW-1:0]   cnt_inc;
    logic [POSW-1:0] step_w, pos_step;
    logic [1:0]      fault_code_d;

    // Edge qualification, step arithmetic and sticky fault update.
    always_comb begin
        disabled     = ~xen_s | xrst_s;
        accept       = edge_q & ~disabled & (state_q != ST_DISABLED);
        reject       = edge_q & ~accept;
        cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + PW'(1);
        step_w       = POSW'(ms_weight(8'(ms_e_q), MSW));
        pos_step     = dir_e_q ? pos_q + step_w : pos_q - step_w;
        fault_code_d = clr_fault ? FAULT_NONE : fault_code_q;
        if (reject) fault_code_d = fault_code_d | FAULT_STEP_DISABLED;
        if (accept && (cnt_inc < MIN_PER)) fault_code_d = fault_code_d | FAULT_OVERSPEED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_DISABLED;
            drive_prev_q   <= 1'b0;
            edge_q         <= 1'b0;
            dir_e_q        <= 1'b0;
            ms_e_q         <= '0;
            first_q        <= 1'b1;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            pos_q          <= '0;
            zpd_q          <= ZPD_RESET;
            moving_q       <= 1'b0;
            fault_q        <= 1'b0;
            fault_code_q   <= FAULT_NONE;
        end else begin
            drive_prev_q   <= drive_s;
            edge_q         <= drive_s & ~drive_prev_q;
            dir_e_q        <= dir_s;
            ms_e_q         <= ms_s;
            period_valid_q <= 1'b0;
            fault_code_q   <= fault_code_d;
            fault_q        <= |fault_code_d;
            zpd_q          <= ($signed(pos_q) <= ZPD_TH);

            // Preload takes priority; a step landing in the same cycle is dropped.
            if (preload_en) pos_q <= preload_val;
            else if (accept) pos_q <= pos_step;

            if (disabled) begin
                state_q  <= ST_DISABLED;
                moving_q <= 1'b0;
                cnt_q    <= '0;
                first_q  <= 1'b1;
            end else begin
                cnt_q <= (state_q == ST_DISABLED) ? '0 : cnt_inc;
                unique case (state_q)
                    ST_DISABLED: begin
                        state_q  <= ST_IDLE;
                        moving_q <= 1'b0;
                    end
                    ST_IDLE: if (accept) begin
                        state_q  <= ST_MOVING;
                        moving_q <= 1'b1;
                    end
                    ST_MOVING: if (!accept && (cnt_q >= IDLE_TO)) begin
                        state_q  <= ST_IDLE;
                        moving_q <= 1'b0;
                    end
                    default: begin
                        state_q  <= ST_DISABLED;
                        moving_q <= 1'b0;
                    end
                endcase
                if (accept) begin
                    cnt_q   <= '0;
                    first_q <= 1'b0;
                    if (!first_q) begin
                        period_q       <= cnt_inc;
                        period_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef STEP_PULSE_TRACKER_REVERSAL_EN
    logic [15:0] rev_q;
    logic        last_dir_q, have_dir_q;

    // Direction changes between consecutive accepted steps; preload restarts history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rev_q      <= '0;
            last_dir_q <= 1'b0;
            have_dir_q <= 1'b0;
        end else if (preload_en) begin
            rev_q      <= '0;
            have_dir_q <= 1'b0;
        end else if (accept) begin
            if (have_dir_q && (dir_e_q != last_dir_q)) rev_q <= rev_q + 16'd1;
            last_dir_q <= dir_e_q;
            have_dir_q <= 1'b1;
        end
    end

    assign o_reversals = rev_q;
`endif

    assign o_position     = pos_q;
    assign o_zpd          = zpd_q;
    assign o_period       = period_q;
    assign o_period_valid = period_valid_q;
    assign o_moving       = moving_q;
    assign o_fault        = fault_q;
    assign o_fault_code   = fault_code_q;

endmodule

// File: tb/tb_step_pulse_tracker.sv
// Self-checking bench for step_pulse_tracker; period updates are scoreboarded,
// position/state/fault checks are inline per scenario.
module tb_step_pulse_tracker;

    localparam int unsigned TIMEOUT = 2000;

    logic        clk, reset;
    logic        m_drive, m_dir, m_xen, m_xrst;
    logic [2:0]  m_ms;
    logic        preload_en, clr_fault;
    logic [31:0] preload_val;
    logic [31:0] o_position;
    logic        o_zpd;
    logic [23:0] o_period;
    logic        o_period_valid, o_moving, o_fault;
    logic [1:0]  o_fault_code;
`ifdef STEP_PULSE_TRACKER_REVERSAL_EN
    logic [15:0] o_reversals;
`endif

    step_pulse_tracker #(
        .C_MICROSTEP_WIDTH (3),
        .C_POSITION_WIDTH  (32),
        .C_PERIOD_WIDTH    (24),
        .C_SYNC_STAGES     (2),
        .C_IDLE_TIMEOUT    (TIMEOUT),
        .C_MIN_PERIOD      (32),
        .C_ZPD_THRESHOLD   (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m_drive        (m_drive),
        .m_dir          (m_dir),
        .m_ms           (m_ms),
        .m_xen          (m_xen),
        .m_xrst         (m_xrst),
        .preload_en     (preload_en),
        .preload_val    (preload_val),
        .clr_fault      (clr_fault),
        .o_position     (o_position),
        .o_zpd          (o_zpd),
        .o_period       (o_period),
        .o_period_valid (o_period_valid),
        .o_moving       (o_moving),
        .o_fault        (o_fault),
        .o_fault_code   (o_fault_code)
`ifdef STEP_PULSE_TRACKER_REVERSAL_EN
       ,.o_reversals    (o_reversals)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed period updates, captured by the monitor and drained by the tests.
    int obs_mem [1024];
    int obs_wr = 0;
    always @(negedge clk) begin
        if (!reset && o_period_valid === 1'b1) begin
            obs_mem[obs_wr % 1024] = int'(o_period);
            obs_wr = obs_wr + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int obs_rd = 0;
    int exp_period_q [$];
    int last_rise = 0;
    bit tb_first = 1'b1;
    bit tb_enabled = 1'b0;
    int tb_pos = 0;

    task automatic drain_scoreboard();
        int e;
        while (obs_rd < obs_wr) begin
            n_vec++;
            if (exp_period_q.size() == 0) begin
                n_err++;
                $display("FAIL period_unexpected: got %0d, none expected", obs_mem[obs_rd % 1024]);
            end else begin
                e = exp_period_q.pop_front();
                if (obs_mem[obs_rd % 1024] !== e) begin
                    n_err++;
                    $display("FAIL period: got %0d expected %0d", obs_mem[obs_rd % 1024], e);
                end
            end
            obs_rd++;
        end
    endtask

    // Model a rising drive edge: expected period push and position update.
    task automatic note_rise(input bit count_pos);
        int w;
        w = 1 << (7 - int'(m_ms));
        if (tb_enabled) begin
            if (!tb_first) exp_period_q.push_back(cyc - last_rise);
            tb_first  = 1'b0;
            last_rise = cyc;
            if (count_pos) tb_pos = m_dir ? tb_pos + w : tb_pos - w;
        end
    endtask

    task automatic drive_pulse(input int period);
        m_drive = 1'b1;
        note_rise(1'b1);
        repeat (period / 2) @(negedge clk);
        m_drive = 1'b0;
        repeat (period - period / 2) @(negedge clk);
        drain_scoreboard();
    endtask

    // Rising edge with a preload/clr strobe aligned to the cycle the step is applied.
    task automatic rise_with_strobe(input bit do_preload, input int val, input bit do_clr, input int period);
        m_drive = 1'b1;
        note_rise(!do_preload);
        repeat (3) @(negedge clk);
        preload_en  = do_preload;
        preload_val = 32'(val);
        clr_fault   = do_clr;
        @(negedge clk);
        preload_en = 1'b0;
        clr_fault  = 1'b0;
        if (do_preload) tb_pos = val;
        @(negedge clk);
        m_drive = 1'b0;
        repeat (period - 5) @(negedge clk);
        drain_scoreboard();
    endtask

    task automatic do_preload(input int val);
        preload_en  = 1'b1;
        preload_val = 32'(val);
        @(negedge clk);
        preload_en = 1'b0;
        tb_pos     = val;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++;
        if (o_position !== 32'd0 || o_zpd !== 1'b1) begin
            n_err++;
            $display("FAIL reset_held: pos=%0d zpd=%b expected pos=0 zpd=1", o_position, o_zpd);
        end
        reset = 1'b0;
        tb_enabled = 1'b1;
        tb_first   = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++;
        if (o_position !== 32'd0 || o_zpd !== 1'b1 || o_moving !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: pos=%0d zpd=%b moving=%b expected 0/1/0", o_position, o_zpd, o_moving);
        end
        n_vec++;
        if (o_fault !== 1'b0 || o_fault_code !== 2'b00 || o_period !== 24'd0 || o_period_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: fault=%b code=%b period=%0d valid=%b expected all 0",
                     o_fault, o_fault_code, o_period, o_period_valid);
        end
    endtask

    task automatic test_fine_steps();
        m_ms  = 3'd7;
        m_dir = 1'b1;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 10; i++) drive_pulse(100);
        n_vec++;
        if ($signed(o_position) !== 32'sd10 || $signed(o_position) !== 32'(tb_pos)) begin
            n_err++;
            $display("FAIL fine_position: got %0d expected 10", $signed(o_position));
        end
        n_vec++;
        if (o_period !== 24'd100 || o_moving !== 1'b1 || o_zpd !== 1'b0 || o_fault !== 1'b0) begin
            n_err++;
            $display("FAIL fine_status: period=%0d moving=%b zpd=%b fault=%b expected 100/1/0/0",
                     o_period, o_moving, o_zpd, o_fault);
        end
    endtask

    task automatic test_coarse_timeout();
        do_preload(300);
        n_vec++;
        if ($signed(o_position) !== 32'sd300) begin
            n_err++;
            $display("FAIL preload_300: got %0d expected 300", $signed(o_position));
        end
        m_ms  = 3'd0;
        m_dir = 1'b0;
        for (int i = 0; i < 3; i++) drive_pulse(100);
        n_vec++;
        if ($signed(o_position) !== -32'sd84 || o_zpd !== 1'b1 || o_moving !== 1'b1) begin
            n_err++;
            $display("FAIL coarse_reverse: pos=%0d zpd=%b moving=%b expected -84/1/1",
                     $signed(o_position), o_zpd, o_moving);
        end
        repeat (1900) @(negedge clk);
        n_vec++;
        if (o_moving !== 1'b1) begin
            n_err++;
            $display("FAIL before_timeout: moving=%b expected 1", o_moving);
        end
        repeat (150) @(negedge clk);
        n_vec++;
        if (o_moving !== 1'b0) begin
            n_err++;
            $display("FAIL after_timeout: moving=%b expected 0", o_moving);
        end
    endtask

    task automatic test_overspeed();
        m_ms  = 3'd7;
        m_dir = 1'b1;
        repeat (5) @(negedge clk);
        drive_pulse(10);
        drive_pulse(100);
        n_vec++;
        if (o_fault !== 1'b1 || o_fault_code !== 2'b10 || $signed(o_position) !== 32'(tb_pos)) begin
            n_err++;
            $display("FAIL overspeed: fault=%b code=%b pos=%0d expected 1/10/%0d",
                     o_fault, o_fault_code, $signed(o_position), tb_pos);
        end
        pulse_clr();
        n_vec++;
        if (o_fault !== 1'b0 || o_fault_code !== 2'b00) begin
            n_err++;
            $display("FAIL clr_fault: fault=%b code=%b expected 0/00", o_fault, o_fault_code);
        end
    endtask

    task automatic test_back_to_back();
        drive_pulse(10);
        rise_with_strobe(1'b0, 0, 1'b1, 100);
        n_vec++;
        if (o_fault !== 1'b1 || o_fault_code !== 2'b10) begin
            n_err++;
            $display("FAIL clr_vs_new_fault: fault=%b code=%b expected 1/10", o_fault, o_fault_code);
        end
        pulse_clr();
    endtask

    task automatic test_disabled();
        m_xen = 1'b0;
        tb_enabled = 1'b0;
        tb_first   = 1'b1;
        repeat (6) @(negedge clk);
        drive_pulse(100);
        n_vec++;
        if ($signed(o_position) !== 32'(tb_pos) || o_fault_code !== 2'b01 || o_fault !== 1'b1 || o_moving !== 1'b0) begin
            n_err++;
            $display("FAIL xen_low_step: pos=%0d code=%b fault=%b moving=%b expected %0d/01/1/0",
                     $signed(o_position), o_fault_code, o_fault, o_moving, tb_pos);
        end
        m_xen = 1'b1;
        tb_enabled = 1'b1;
        pulse_clr();
        repeat (50) @(negedge clk);
        m_xrst = 1'b1;
        tb_enabled = 1'b0;
        tb_first   = 1'b1;
        repeat (6) @(negedge clk);
        drive_pulse(100);
        n_vec++;
        if ($signed(o_position) !== 32'(tb_pos) || o_fault_code !== 2'b01 || o_moving !== 1'b0) begin
            n_err++;
            $display("FAIL xrst_retain: pos=%0d code=%b moving=%b expected %0d/01/0",
                     $signed(o_position), o_fault_code, o_moving, tb_pos);
        end
        m_xrst = 1'b0;
        tb_enabled = 1'b1;
        pulse_clr();
        repeat (50) @(negedge clk);
        drive_pulse(100);
        n_vec++;
        if ($signed(o_position) !== 32'(tb_pos) || o_fault_code !== 2'b00 || o_moving !== 1'b1) begin
            n_err++;
            $display("FAIL reenable_step: pos=%0d code=%b moving=%b expected %0d/00/1",
                     $signed(o_position), o_fault_code, o_moving, tb_pos);
        end
    endtask

    task automatic test_preload_collision();
        drive_pulse(100);
        rise_with_strobe(1'b1, -5, 1'b0, 100);
        n_vec++;
        if ($signed(o_position) !== -32'sd5 || o_zpd !== 1'b1) begin
            n_err++;
            $display("FAIL preload_collision: pos=%0d zpd=%b expected -5/1", $signed(o_position), o_zpd);
        end
    endtask

`ifdef STEP_PULSE_TRACKER_REVERSAL_EN
    task automatic test_reversals();
        bit dirs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_preload(0);
        n_vec++;
        if (o_reversals !== 16'd0) begin
            n_err++;
            $display("FAIL reversals_cleared: got %0d expected 0", o_reversals);
        end
        m_ms = 3'd7;
        for (int i = 0; i < 4; i++) begin
            m_dir = dirs[i];
            drive_pulse(100);
        end
        n_vec++;
        if (o_reversals !== 16'd2 || $signed(o_position) !== 32'(tb_pos)) begin
            n_err++;
            $display("FAIL reversals: got %0d pos=%0d expected 2/%0d", o_reversals, $signed(o_position), tb_pos);
        end
    endtask
`endif

    initial begin
        reset       = 1'b1;
        m_drive     = 1'b0;
        m_dir       = 1'b0;
        m_ms        = 3'd0;
        m_xen       = 1'b1;
        m_xrst      = 1'b0;
        preload_en  = 1'b0;
        preload_val = 32'd0;
        clr_fault   = 1'b0;
        @(negedge clk);
        test_reset();
        test_fine_steps();
        test_coarse_timeout();
        test_overspeed();
        test_back_to_back();
        test_disabled();
        test_preload_collision();
`ifdef STEP_PULSE_TRACKER_REVERSAL_EN
        test_reversals();
`endif
        repeat (20) @(negedge clk);
        drain_scoreboard();
        n_vec++;
        if (exp_period_q.size() != 0) begin
            n_err++;
            $display("FAIL period_missing: %0d expected updates never seen", exp_period_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
